// File: rtl/mips_pkg.sv
// Shared decode-stage definitions for the MIPS datapath.
// Holds the immediate extension mode encodings and the default widths of the
// raw immediate field and the extended operand.
package mips_pkg;

   localparam int IMM_IN_W  = 16;
   localparam int IMM_OUT_W = 32;

   typedef enum logic [1:0] {
      IMM_SEXT  = 2'd0,
      IMM_ZEXT  = 2'd1,
      IMM_LUI   = 2'd2,
      IMM_BROFF = 2'd3
   } imm_mode_e;

endpackage : mips_pkg

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender.
// Ports:
//   inst  [IN_W-1:0]  raw immediate field
//   mode  [1:0]       extension mode (SEXT, ZEXT, LUI, BROFF)
//   ext   [OUT_W-1:0] extended operand
module imm_ext_core
   import mips_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W
) (
   input  logic [IN_W-1:0]  inst,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] ext
);

   logic signed [IN_W-1:0]  inst_s;
   logic signed [OUT_W-1:0] sext;
   logic        [OUT_W-1:0] zext;
   logic        [OUT_W-1:0] lui;
   logic        [OUT_W-1:0] broff;

   // Signed-to-signed assignment into the wider vector replicates the sign bit.
   assign inst_s = inst;
   assign sext   = inst_s;
   assign zext   = {{(OUT_W-IN_W){1'b0}}, inst};
   // Concatenation equals (inst << (OUT_W-IN_W)) truncated to OUT_W for any legal width.
   assign lui    = {inst, {(OUT_W-IN_W){1'b0}}};
   // Word-aligned branch offset: the two top sign bits fall off the end.
   assign broff  = {sext[OUT_W-3:0], 2'b00};

   always_comb begin
      ext = sext;
      unique case (imm_mode_e'(mode))
         IMM_SEXT:  ext = sext;
         IMM_ZEXT:  ext = zext;
         IMM_LUI:   ext = lui;
         IMM_BROFF: ext = broff;
         default:   ext = sext;
      endcase
   end

endmodule : imm_ext_core

// File: rtl/imm_ext_stage.sv
// Registered immediate extender for the decode stage.
// Extends the accepted immediate and keeps up to two results in a small FIFO
// so decode can stall or be flushed without losing or duplicating operands.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   flush                 drop all buffered entries at the next edge
//   in_valid / in_ready   producer handshake (in_ready depends on state only)
//   inst [IN_W-1:0]       raw immediate field, sampled on push
//   mode [1:0]            extension mode, sampled on push
//   out_valid / out_ready consumer handshake
//   data [OUT_W-1:0]      extended operand at the buffer head
//   count [1:0]           occupancy 0..2
module imm_ext_stage
   import mips_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  inst,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] data,
   output logic [1:0]       count
);

   if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_ext_stage: OUT_W must be at least IN_W+2");
   end
   if (DEPTH != 2) begin : g_bad_depth
      $error("imm_ext_stage: DEPTH must be 2");
   end

   logic [OUT_W-1:0] ext;
   logic [OUT_W-1:0] mem_q [2];
   logic [OUT_W-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             push, pop;

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .inst (inst),
      .mode (mode),
      .ext  (ext)
   );

   // Handshake derived from registered occupancy only
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign data      = mem_q[rd_ptr_q];
   assign count     = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         // Flush wins over a same-cycle push or pop; the pushed item is dropped.
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = ext;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Buffer register stage; storage is cleared on reset so data reads 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule : imm_ext_stage

// File: tb/tb_imm_ext_stage.sv
module tb_imm_ext_stage;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] inst;
   logic [1:0]  mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data;
   logic [1:0]  count;

   logic        in_valid2;
   logic        in_ready2;
   logic [11:0] inst2;
   logic [1:0]  mode2;
   logic        out_valid2;
   logic        out_ready2;
   logic [15:0] data2;
   logic [1:0]  count2;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q [$];

   imm_ext_stage u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready), .data(data), .count(count)
   );

   imm_ext_stage #(.IN_W(12), .OUT_W(16), .DEPTH(2)) u_dut2 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid2), .in_ready(in_ready2), .inst(inst2), .mode(mode2),
      .out_valid(out_valid2), .out_ready(out_ready2), .data(data2), .count(count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference extension from the arithmetic meaning of each mode.
   function automatic logic [31:0] ref_ext(input int in_w, input int out_w,
                                           input longint raw, input int md);
      longint s   = raw;
      longint m   = longint'(1) << out_w;
      longint r   = 0;
      if (raw >= (longint'(1) << (in_w - 1))) s = raw - (longint'(1) << in_w);
      case (md)
         0: r = s;
         1: r = raw;
         2: r = raw * (longint'(1) << (out_w - in_w));
         default: r = s * 4;
      endcase
      r = ((r % m) + m) % m;
      return r[31:0];
   endfunction

   // Drive one cycle of stimulus; the scoreboard is updated mid-cycle once
   // the registered in_ready for this cycle is known.
   task automatic step(input bit v, input logic [15:0] i, input logic [1:0] m,
                       input bit ordy, input bit fl, input bit rs);
      in_valid  = v;
      inst      = i;
      mode      = m;
      out_ready = ordy;
      flush     = fl;
      reset     = rs;
      #2;
      if (rs || fl) exp_q.delete();
      else if (v && in_ready) exp_q.push_back(ref_ext(16, 32, longint'(i), int'(m)));
      @(posedge clk);
      #1;
   endtask

   // Monitor: every consumer take is compared with the scoreboard head.
   always @(negedge clk) begin
      if (!reset && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got %h expected no output at %0t", data, $time);
         end else begin
            check("scoreboard_data", data, exp_q.pop_front());
         end
      end
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; inst = '0; mode = '0; out_ready = 1'b0;
      in_valid2 = 1'b0; inst2 = '0; mode2 = '0; out_ready2 = 1'b0;
      @(posedge clk); #1;
      step(0, 16'h0, 2'd0, 0, 0, 1);
      step(0, 16'h0, 2'd0, 0, 0, 0);
      check("reset_count", 32'(count), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_data", data, 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);

      // Narrow instance: BROFF then LUI of 12'h800
      in_valid2 = 1'b1; inst2 = 12'h800; mode2 = 2'd3;
      step(0, 16'h0, 2'd0, 0, 0, 0);
      in_valid2 = 1'b1; inst2 = 12'h800; mode2 = 2'd2;
      step(0, 16'h0, 2'd0, 0, 0, 0);
      check("narrow_broff", 32'(data2), 32'h0000E000);
      check("narrow_count", 32'(count2), 32'd2);
      in_valid2 = 1'b0; out_ready2 = 1'b1;
      step(0, 16'h0, 2'd0, 0, 0, 0);
      check("narrow_lui", 32'(data2), 32'h00008000);
      out_ready2 = 1'b0;

      // SEXT
      step(1, 16'h8004, 2'd0, 1, 0, 0);
      check("sext_valid", 32'(out_valid), 32'd1);
      check("sext_data", data, 32'hFFFF8004);
      step(0, 16'h0, 2'd0, 1, 0, 0);
      check("sext_drained", 32'(out_valid), 32'd0);

      // All modes back-to-back
      step(1, 16'hFFFE, 2'd1, 1, 0, 0);
      check("zext_data", data, 32'h0000FFFE);
      step(1, 16'hFFFE, 2'd2, 1, 0, 0);
      check("lui_data", data, 32'hFFFE0000);
      step(1, 16'hFFFE, 2'd3, 1, 0, 0);
      check("broff_data", data, 32'hFFFFFFF8);
      step(0, 16'h0, 2'd0, 1, 0, 0);
      check("modes_drained", 32'(out_valid), 32'd0);

      // Backpressure
      step(1, 16'h0001, 2'd0, 0, 0, 0);
      step(1, 16'h0002, 2'd0, 0, 0, 0);
      check("bp_count_full", 32'(count), 32'd2);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      step(1, 16'h0003, 2'd0, 0, 0, 0);
      check("bp_third_rejected", 32'(count), 32'd2);
      check("bp_head_held", data, 32'd1);
      step(1, 16'h0003, 2'd0, 1, 0, 0);
      check("bp_after_pop", data, 32'd2);
      step(1, 16'h0003, 2'd0, 1, 0, 0);
      check("bp_third_head", data, 32'd3);
      step(0, 16'h0, 2'd0, 1, 0, 0);
      check("bp_drained", 32'(out_valid), 32'd0);

      // Flush with a competing push and pop
      step(1, 16'h0010, 2'd1, 0, 0, 0);
      step(1, 16'h0020, 2'd1, 0, 0, 0);
      check("flush_pre_count", 32'(count), 32'd2);
      step(1, 16'h1234, 2'd1, 1, 1, 0);
      check("flush_count", 32'(count), 32'd0);
      check("flush_valid", 32'(out_valid), 32'd0);
      step(0, 16'h0, 2'd0, 1, 0, 0);
      step(0, 16'h0, 2'd0, 1, 0, 0);
      check("flush_no_ghost", 32'(out_valid), 32'd0);

      // Reset mid-operation with push and pop active
      step(1, 16'h0055, 2'd2, 0, 0, 0);
      step(1, 16'h0066, 2'd2, 0, 0, 0);
      step(1, 16'h0077, 2'd2, 1, 0, 1);
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_data", data, 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      step(0, 16'h0, 2'd0, 0, 0, 0);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom_range(0, 3)),
              $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, 0);
      end

      // Drain, bounded
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(0, 16'h0, 2'd0, 1, 0, 0);
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
      check("drain_out_valid", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_imm_ext_stage
